// File: rtl/time_set_controller_pkg.sv
// Mode codes and helpers shared by the time-set sequencer and the display logic.
// The display blinks the field selected by the current mode code.
package time_set_controller_pkg;

  localparam int MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam logic [MODE_W-1:0] RUN         = 3'd0;
  localparam logic [MODE_W-1:0] SET_HR      = 3'd1;
  localparam logic [MODE_W-1:0] SET_MIN     = 3'd2;
  localparam logic [MODE_W-1:0] SET_ALM_HR  = 3'd3;
  localparam logic [MODE_W-1:0] SET_ALM_MIN = 3'd4;

  function automatic logic is_legal(input mode_t m);
    return m <= SET_ALM_MIN;
  endfunction

  // The user walks the modes in a fixed ring; anything unknown lands in RUN.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:         return SET_HR;
      SET_HR:      return SET_MIN;
      SET_MIN:     return SET_ALM_HR;
      SET_ALM_HR:  return SET_ALM_MIN;
      default:     return RUN;
    endcase
  endfunction

  // Time keeps running while the alarm is being edited.
  function automatic logic clock_runs(input mode_t m);
    return (m == RUN) || (m == SET_ALM_HR) || (m == SET_ALM_MIN);
  endfunction

endpackage

// File: rtl/time_set_controller_auto_repeat.sv
// Turns the increment button level into single-cycle increment requests:
// one on the press, then auto-repeat after a long hold.
module auto_repeat
  import time_set_controller_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_btn,
  input  logic clear,
  output logic inc_pulse
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  logic          inc_prev;
  logic          rise_q;
  logic          armed;
  logic          repeating;
  logic [CW-1:0] cnt;
  logic          rise;
  logic          hit;

  assign rise = inc_btn & ~inc_prev;
  assign hit  = armed & (repeating ? (cnt == REPEAT_LAST) : (cnt == HOLD_LAST));

  // A repeat only fires if the button is still down on the edge it would land on.
  assign inc_pulse = rise_q | (hit & inc_btn & ~clear);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_prev  <= 1'b0;
      rise_q    <= 1'b0;
      armed     <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
    end else begin
      inc_prev <= inc_btn;
      rise_q   <= rise & ~clear;
      if (clear || !inc_btn) begin
        armed     <= 1'b0;
        repeating <= 1'b0;
        cnt       <= '0;
      end else if (rise) begin
        armed     <= 1'b1;
        repeating <= 1'b0;
        cnt       <= '0;
      end else if (armed) begin
        if (hit) begin
          repeating <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Mode sequencer, one-second prescaler and load-pulse decode for the alarm
// clock's timekeeping chain.
module time_set_controller
  import time_set_controller_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_btn,
  input  logic              inc_btn,
  output logic              sec_tick,
  output logic              run_enable,
  output logic              sec_clear,
  output logic              min_load,
  output logic              hour_load,
  output logic              alm_min_load,
  output logic              alm_hour_load,
  output logic [MODE_W-1:0] mode
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  mode_t         state;
  mode_t         next_state;
  logic          mode_prev;
  logic          mode_rise_q;
  logic          inc_pulse;
  logic          inc_clear;
  logic          take_inc;
  logic [PW-1:0] presc;

  auto_repeat #(
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES)
  ) u_auto_repeat (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_btn   (inc_btn),
    .clear     (inc_clear),
    .inc_pulse (inc_pulse)
  );

  always_comb begin
    next_state = state;
    if (!is_legal(state)) begin
      next_state = RUN;
    end else if (mode_rise_q) begin
      next_state = next_mode(state);
    end
  end

  // A mode change wins over an increment landing on the same edge.
  assign inc_clear = mode_rise_q | (state == RUN) | ~is_legal(state);
  assign take_inc  = inc_pulse & ~mode_rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      mode_prev     <= 1'b0;
      mode_rise_q   <= 1'b0;
      run_enable    <= 1'b1;
      sec_clear     <= 1'b0;
      min_load      <= 1'b0;
      hour_load     <= 1'b0;
      alm_min_load  <= 1'b0;
      alm_hour_load <= 1'b0;
    end else begin
      mode_prev     <= mode_btn;
      mode_rise_q   <= mode_btn & ~mode_prev;
      state         <= next_state;
      run_enable    <= clock_runs(next_state);
      sec_clear     <= mode_rise_q && (state == SET_MIN);
      hour_load     <= take_inc && (state == SET_HR);
      min_load      <= take_inc && (state == SET_MIN);
      alm_hour_load <= take_inc && (state == SET_ALM_HR);
      alm_min_load  <= take_inc && (state == SET_ALM_MIN);
    end
  end

  // Seconds restart from a full period whenever time setting pauses the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else if (!run_enable) begin
      presc    <= '0;
      sec_tick <= 1'b0;
    end else if (presc == PRESC_LAST) begin
      presc    <= '0;
      sec_tick <= 1'b1;
    end else begin
      presc    <= presc + PW'(1);
      sec_tick <= 1'b0;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus random
// button sessions compared against a press-age reference model.
module tb_time_set_controller;

  localparam int T = 10;
  localparam int H = 8;
  localparam int R = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       sec_tick, run_enable, sec_clear;
  logic       min_load, hour_load, alm_min_load, alm_hour_load;
  logic [2:0] mode;

  time_set_controller #(
    .TICKS_PER_SEC (T),
    .HOLD_CYCLES   (H),
    .REPEAT_CYCLES (R)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mode_btn      (mode_btn),
    .inc_btn       (inc_btn),
    .sec_tick      (sec_tick),
    .run_enable    (run_enable),
    .sec_clear     (sec_clear),
    .min_load      (min_load),
    .hour_load     (hour_load),
    .alm_min_load  (alm_min_load),
    .alm_hour_load (alm_hour_load),
    .mode          (mode)
  );

  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_pass = 0;
  int       m_mode;
  bit       m_run, m_tick, m_clear;
  bit [3:0] m_loads;
  bit       p_mode, p_first, prev_m, prev_i, cancelled;
  int       age, tick_c;
  int       tick_seen, clear_seen, load_seen;
  int       load_cnt [4];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 1'b1; m_tick = 1'b0; m_clear = 1'b0; m_loads = '0;
    p_mode = 1'b0; p_first = 1'b0; prev_m = 1'b0; prev_i = 1'b0; cancelled = 1'b0;
    age = 0; tick_c = 0;
  endtask

  // Expected outputs after one clock edge, from the rules: presses take effect one
  // edge late, repeats follow from how long the button has been held.
  task automatic model_edge(input bit m, input bit i);
    int old_mode;
    bit old_run, rise_i, req, take;
    old_mode = m_mode;
    old_run  = m_run;
    rise_i   = i && !prev_i;
    m_clear  = p_mode && (old_mode == 2);
    m_mode   = p_mode ? (old_mode + 1) % 5 : old_mode;
    if (old_run) begin
      tick_c = tick_c + 1;
      m_tick = (tick_c == T);
      if (m_tick) tick_c = 0;
    end else begin
      tick_c = 0;
      m_tick = 1'b0;
    end
    m_run = !(m_mode == 1 || m_mode == 2);
    age = i ? (prev_i ? age + 1 : 1) : 0;
    if (p_mode) cancelled = 1'b1;
    else if (rise_i) cancelled = 1'b0;
    req  = p_first || (i && !cancelled && age > H && ((age - H - 1) % R == 0));
    take = req && !p_mode && (old_mode != 0);
    m_loads = '0;
    if (take) begin
      case (old_mode)
        1: m_loads[1] = 1'b1;
        2: m_loads[0] = 1'b1;
        3: m_loads[3] = 1'b1;
        4: m_loads[2] = 1'b1;
        default: m_loads = '0;
      endcase
    end
    p_first = rise_i && !p_mode && (old_mode != 0);
    p_mode  = m && !prev_m;
    prev_m  = m;
    prev_i  = i;
  endtask

  task automatic check_output();
    logic [3:0] loads;
    loads = {alm_hour_load, alm_min_load, hour_load, min_load};
    check("mode", 8'(mode), 8'(m_mode));
    check("run_enable", 8'(run_enable), 8'(m_run));
    check("sec_tick", 8'(sec_tick), 8'(m_tick));
    check("sec_clear", 8'(sec_clear), 8'(m_clear));
    check("loads", 8'(loads), 8'(m_loads));
    check("load_onehot", 8'($countones(loads) <= 1), 8'd1);
    tick_seen  = tick_seen + int'(sec_tick);
    clear_seen = clear_seen + int'(sec_clear);
    load_seen  = load_seen + $countones(loads);
    for (int k = 0; k < 4; k++) load_cnt[k] = load_cnt[k] + int'(loads[k]);
  endtask

  task automatic clear_counts();
    tick_seen = 0; clear_seen = 0; load_seen = 0;
    for (int k = 0; k < 4; k++) load_cnt[k] = 0;
  endtask

  task automatic apply_stimulus(input bit m, input bit i);
    mode_btn = m;
    inc_btn  = i;
    @(posedge clk);
    model_edge(m, i);
    @(negedge clk);
    check_output();
  endtask

  task automatic press_mode(input int n);
    for (int k = 0; k < n; k++) begin
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0);
  endtask

  task automatic press_inc(input int len);
    for (int k = 0; k < len; k++) apply_stimulus(1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0);
  endtask

  initial begin
    int n, len;
    model_reset();
    clear_counts();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_output();
    rst_n = 1'b1;

    // Idle: ticks at 10, 20, 30
    clear_counts();
    repeat (35) apply_stimulus(1'b0, 1'b0);
    check("idle_ticks", 8'(tick_seen), 8'd3);

    // Full mode ring, one sec_clear
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b0);
      check("ring_mode", 8'(mode), 8'((k + 1) % 5));
      apply_stimulus(1'b0, 1'b0);
    end
    check("ring_clears", 8'(clear_seen), 8'd1);

    // Short press in SET_MIN, then in RUN
    press_mode(2);
    clear_counts();
    press_inc(2);
    repeat (3) apply_stimulus(1'b0, 1'b0);
    check("setmin_min_load", 8'(load_cnt[0]), 8'd1);
    check("setmin_total", 8'(load_seen), 8'd1);
    press_mode(3);
    clear_counts();
    press_inc(2);
    repeat (3) apply_stimulus(1'b0, 1'b0);
    check("run_no_load", 8'(load_seen), 8'd0);

    // 20-cycle hold in SET_ALM_HR
    press_mode(3);
    clear_counts();
    press_inc(20);
    repeat (3) apply_stimulus(1'b0, 1'b0);
    check("hold_alm_hour", 8'(load_cnt[3]), 8'd4);
    check("hold_total", 8'(load_seen), 8'd4);

    // Mode and inc rise together in SET_HR
    press_mode(3);
    clear_counts();
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1);
    repeat (3) apply_stimulus(1'b0, 1'b0);
    check("simul_mode", 8'(mode), 8'd2);
    check("simul_hour", 8'(load_cnt[1]), 8'd0);

    // Async reset during auto-repeat in SET_ALM_MIN
    press_mode(2);
    for (int k = 0; k < 12; k++) apply_stimulus(1'b0, 1'b1);
    #2 rst_n = 1'b0;
    inc_btn = 1'b0;
    #1;
    check("rst_mode", 8'(mode), 8'd0);
    check("rst_run", 8'(run_enable), 8'd1);
    check("rst_pulses", 8'({sec_tick, sec_clear, min_load, hour_load, alm_min_load, alm_hour_load}), 8'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    repeat (15) apply_stimulus(1'b0, 1'b0);
    check("post_rst_loads", 8'(load_seen), 8'd0);

    // Random sessions
    for (int it = 0; it < 30; it++) begin
      n = int'($urandom_range(0, 4));
      press_mode(n);
      len = int'($urandom_range(1, 22));
      for (int k = 0; k < len; k++) begin
        if (k > 0 && $urandom_range(0, 15) == 0) apply_stimulus(1'b1, 1'b1);
        else apply_stimulus(1'b0, 1'b1);
      end
      repeat ($urandom_range(1, 3)) apply_stimulus(1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
# time_set_controller

Sequencer for the alarm clock's timekeeping datapath. It generates the one-second tick and the run enable that gate the seconds/minutes/hours chain. It also runs the mode state machine that walks the user through setting time and alarm, converting the debounced `mode_btn`/`inc_btn` presses into single-cycle load pulses for the minute and hour counters and their alarm counterparts. It sits between the button debouncers and the counter/enabler chain.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100_000_000: clk cycles per one-second tick.
- `HOLD_CYCLES`, default 50_000_000: cycles `inc_btn` must stay high before auto-repeat starts.
- `REPEAT_CYCLES`, default 20_000_000: cycles between auto-repeat pulses.

Ports:
- `clk` input 1: single system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mode_btn` input 1: debounced, synchronous level; its rising edge advances the mode.
- `inc_btn` input 1: debounced, synchronous level; its rising edge (plus auto-repeat) requests an increment.
- `sec_tick` output 1: one-cycle pulse, once per second, only in the clock-running modes.
- `run_enable` output 1: enable for the time chain; 0 while setting time.
- `sec_clear` output 1: one-cycle pulse that zeroes the seconds counter.
- `min_load` output 1: one-cycle advance pulse to the time-minute counter loader.
- `hour_load` output 1: one-cycle advance pulse to the time-hour counter loader.
- `alm_min_load` output 1: one-cycle advance pulse to the alarm-minute counter.
- `alm_hour_load` output 1: one-cycle advance pulse to the alarm-hour counter.
- `mode` output 3: current state code, for display blinking.

## Operation
- **States and codes:** RUN=0, SET_HR=1, SET_MIN=2, SET_ALM_HR=3, SET_ALM_MIN=4. Codes 5–7 are illegal and go to RUN on the next clock.
- **Transitions:** a `mode_btn` rising edge steps RUN→SET_HR→SET_MIN→SET_ALM_HR→SET_ALM_MIN→RUN. No other transitions.
- **Edge detect:** one registered copy of each button; rise = current & ~previous.
- **`run_enable`:**
  - 1 in RUN, SET_ALM_HR and SET_ALM_MIN, so the clock keeps running while the alarm is set.
  - 0 in SET_HR and SET_MIN.
- **Prescaler:**
  - A counter of width $clog2(TICKS_PER_SEC) counts 0..TICKS_PER_SEC-1 while `run_enable`=1.
  - `sec_tick` is asserted in the cycle the count equals TICKS_PER_SEC-1, and the count wraps to 0.
  - The count is held at 0 while `run_enable`=0.
- **`sec_clear`:** pulses for one cycle on the SET_MIN→SET_ALM_HR transition, so seconds restart from 00 when the user finishes setting time.
- **Increment requests:**
  - An `inc_btn` rise in a set state pulses the load output for that state: SET_HR→`hour_load`, SET_MIN→`min_load`, SET_ALM_HR→`alm_hour_load`, SET_ALM_MIN→`alm_min_load`.
  - In RUN, `inc_btn` is ignored.
- **Auto-repeat:**
  - The hold counter resets on an `inc_btn` rise and counts while `inc_btn`=1 in a set state.
  - On reaching HOLD_CYCLES it emits a load pulse, then one further pulse every REPEAT_CYCLES for as long as the button stays high.
  - It clears when `inc_btn`=0 or on any mode change.
- **Simultaneous events:** a `mode_btn` rise in the same cycle as an increment (edge or repeat) changes mode only; the increment is dropped and the hold counter clears.
- **Exclusivity:** at most one of the four load outputs is high in any cycle.

## Timing
- Reset (async assert): state=RUN, `mode`=0, `run_enable`=1, prescaler=0, hold counter=0, edge registers=0. `sec_tick`, `sec_clear` and all load outputs are 0.
- Reset release: the first `sec_tick` arrives TICKS_PER_SEC cycles after the first active clock edge.
- All outputs are registered. A button rise sampled at edge N produces its load pulse and mode change at edge N+1 (latency 1 cycle after the edge-detect register).
- `sec_clear` and the new `mode` appear on the same edge.
- Reset asserted mid-operation aborts any auto-repeat at once and drops all pulse outputs to 0 asynchronously.

## Structure
- A shared package holds the state enum/localparams (RUN..SET_ALM_MIN) and the 3-bit mode width; the display logic imports the same codes.
- One sub-module, `auto_repeat`: an `inc_btn` level plus a clear input go in; a single-cycle `inc_pulse` comes out, covering edge detect, hold counter and repeat counter.
- The FSM, prescaler and output decode stay in the top level.

## Test plan
Run with TICKS_PER_SEC=10, HOLD_CYCLES=8, REPEAT_CYCLES=4.
1. Reset, then idle 35 cycles → `sec_tick` pulses at cycles 10, 20 and 30; `run_enable`=1; `mode`=0.
2. Five `mode_btn` pulses → `mode` steps 1, 2, 3, 4, 0. `run_enable` is 0 only at modes 1–2. Exactly one `sec_clear` pulse, on the 2→3 transition.
3. In SET_MIN, one 2-cycle `inc_btn` press → exactly one `min_load` pulse and no other load pulse. In RUN the same press → no load pulse at all.
4. In SET_ALM_HR, hold `inc_btn` for 20 cycles → `alm_hour_load` pulses at press+1, press+8, press+12 and press+16 (4 total).
5. `mode_btn` and `inc_btn` rise in the same cycle in SET_HR → `mode`=2 and no `hour_load`.
6. Assert `rst_n` low in the middle of an auto-repeat in SET_ALM_MIN → all outputs drop immediately; after release, `mode`=0 and no pulse appears until new stimulus.
